significand_div: RTL
====================

# significand_div

Iterative significand divider for the FPU divide path, the counterpart to the significand multiplier on the multiply path. Accepts two normalized significands, produces a normalized, rounded 23-bit quotient fraction plus exponent-adjust and status flags. Uses one restoring-division bit per clock with a start/done handshake. Sits between divide operand unpack/denormal-normalize and the exponent/pack stage.

## Interface
- WIDTH, 24, significand width including hidden bit; Mz is WIDTH-1 bits; iterations = WIDTH+3.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  operand-valid strobe; sampled only in IDLE.
- Mx  in  24  dividend significand, bit 23 = hidden bit.
- My  in  24  divisor significand, bit 23 = hidden bit.
- R_mode  in  2  rounding: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- Sz  in  1  result sign, used by directed rounding.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when results are valid.
- Mz  out  23  rounded quotient fraction, hidden bit dropped.
- exp_dec  out  1  quotient < 1; normalized by 1-bit left shift; exponent stage subtracts 1.
- inexact  out  1  guard | sticky.
- div_by_zero  out  1  My == 0.

## Operation
- States: IDLE, DIV, ROUND. RST forces IDLE from any state, mid-operation included.
- RST clears busy, done, Mz, exp_dec, inexact and div_by_zero to 0.
- IDLE, start=1: latch Mx, My, R_mode, Sz. Set remainder r = Mx (25 bits), q = 0 (27 bits), counter = 26. Go to DIV.
- DIV, each cycle:
  - qbit = (r >= {1'b0,My}).
  - r <= (r - qbit·My) << 1.
  - q <= {q[25:0], qbit}.
  - At counter = 0, go to ROUND; otherwise decrement.
- After 27 iterations, q = floor(Mx·2^26 / My) and S0 = (r != 0).
- ROUND, normalization:
  - q[26]=1: mant = q[25:3], G = q[2], S = q[1] | q[0] | S0, exp_dec = 0.
  - q[26]=0: mant = q[24:2], G = q[1], S = q[0] | S0, exp_dec = 1.
- ROUND, increment:
  - 00: G & (S | mant[0]).
  - 01: 0.
  - 10: ~Sz & (G|S).
  - 11: Sz & (G|S).
- Mz = mant + inc. Normalized operands cannot carry out of the fraction, so there is no round-overflow output. inexact = G|S.
- Special cases still run the full iteration count so latency is fixed:
  - My == 0: div_by_zero=1, Mz=0, exp_dec=0, inexact=0.
  - Mx == 0, My != 0: Mz=0, exp_dec=0, inexact=0, div_by_zero=0.
- A nonzero operand with bit 23 = 0 is outside the contract; output is unspecified.
- start while busy is ignored. Latched operands do not change.
- Outputs hold their values from the last ROUND until the next ROUND or RST.

## Timing
- Edge 0 samples start in IDLE; busy=1 after edge 0.
- Edges 1..27 perform the 27 DIV iterations.
- Edge 28 performs ROUND: it registers the outputs, sets done=1, busy=0, state IDLE.
- done is high for exactly the cycle after edge 28; Mz and the flags are valid from that cycle on.
- start is not accepted at edge 28. The earliest next acceptance is edge 29, giving a 29-cycle issue interval.
- start high in the done cycle is accepted at edge 29.
- RST asserted at any edge overrides start and all state. A later operation behaves as from a fresh reset.

## Test plan
- Mx=0x800000, My=0x800000, RNE, start at edge 0 -> done after edge 28 only; Mz=0x000000, exp_dec=0, inexact=0.
- Mx=0xC00000, My=0x800000, RNE -> Mz=0x400000, exp_dec=0, inexact=0.
- Mx=0x800000, My=0xC00000 -> exp_dec=1, inexact=1 in every mode; Mz by mode:
  - RNE: 0x2AAAAB.
  - RTZ: 0x2AAAAA.
  - R_mode=11, Sz=1: 0x2AAAAB.
  - R_mode=11, Sz=0: 0x2AAAAA.
- Mx=0xFFFFFE, My=0xFFFFFF -> exp_dec=1, inexact=1; Mz=0x7FFFFF for RNE, 0x7FFFFE for RTZ.
- My=0 -> div_by_zero=1, Mz=0, done after edge 28. Mx=0, My=0x900000 -> Mz=0, all flags 0.
- Handshake and reset:
  - start pulses at edges 5 and 28 -> both ignored; the first result is unchanged.
  - start at edge 29 -> accepted.
  - RST at edge 10 of an operation -> IDLE, all outputs 0, no done pulse; the next operation is correct.

Source files
------------

// File: rtl/significand_div.sv
`default_nettype none
// ============================================================================
// Module      : significand_div
// Description : Iterative restoring significand divider for the FPU divide
//               path. Retires one quotient bit per clock over WIDTH+3
//               iterations, then normalizes and rounds the quotient to a
//               WIDTH-1 bit fraction with exponent-adjust and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module significand_div #(
    parameter int WIDTH = 24
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [WIDTH-1:0]   Mx,
    input  logic [WIDTH-1:0]   My,
    input  logic [1:0]         R_mode,
    input  logic               Sz,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-2:0]   Mz,
    output logic               exp_dec,
    output logic               inexact,
    output logic               div_by_zero
);

    // Quotient carries the integer bit, WIDTH-1 fraction bits, guard and one
    // extra bit that feeds sticky; the remainder needs one bit of headroom.
    localparam int c_QW   = WIDTH + 3;
    localparam int c_RW   = WIDTH + 1;
    localparam int c_CW   = $clog2(c_QW);
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(c_QW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [c_RW-1:0]    r_rem;
    logic [c_QW-1:0]    r_q;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_my;
    logic [1:0]         r_mode;
    logic               r_sz;
    logic               r_x_zero;
    logic               r_y_zero;

    logic               r_done;
    logic [WIDTH-2:0]   r_mz;
    logic               r_exp_dec;
    logic               r_inexact;
    logic               r_dbz;

    logic               w_qbit;
    logic [c_RW-1:0]    w_diff;
    logic [c_RW-1:0]    w_rem_next;

    logic [WIDTH-2:0]   w_mant;
    logic               w_g;
    logic               w_s;
    logic               w_inc;
    logic               w_ed;
    logic [WIDTH-2:0]   w_mz;
    logic               w_ed_out;
    logic               w_inx_out;
    logic               w_dbz_out;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state: accept only in IDLE, fixed iteration count, single ROUND.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DIV;
            S_DIV:   if (r_cnt == '0) w_next = S_ROUND;
            S_ROUND: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One restoring step: subtract the divisor when it fits, then shift left.
    always_comb begin
        w_qbit     = (r_rem >= {1'b0, r_my});
        w_diff     = r_rem - (w_qbit ? {1'b0, r_my} : '0);
        w_rem_next = w_diff << 1;
    end

    // Normalize the quotient, pick the rounding increment, resolve specials.
    always_comb begin
        if (r_q[c_QW-1]) begin
            w_mant = r_q[c_QW-2:3];
            w_g    = r_q[2];
            w_s    = r_q[1] | r_q[0] | (|r_rem);
            w_ed   = 1'b0;
        end else begin
            w_mant = r_q[c_QW-3:2];
            w_g    = r_q[1];
            w_s    = r_q[0] | (|r_rem);
            w_ed   = 1'b1;
        end
        case (r_mode)
            2'b00:   w_inc = w_g & (w_s | w_mant[0]);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = ~r_sz & (w_g | w_s);
            default: w_inc = r_sz & (w_g | w_s);
        endcase
        // Normalized operands keep the quotient below 2, so no carry-out.
        w_mz      = w_mant + {{(WIDTH-2){1'b0}}, w_inc};
        w_ed_out  = w_ed;
        w_inx_out = w_g | w_s;
        w_dbz_out = 1'b0;
        if (r_y_zero) begin
            w_mz      = '0;
            w_ed_out  = 1'b0;
            w_inx_out = 1'b0;
            w_dbz_out = 1'b1;
        end else if (r_x_zero) begin
            w_mz      = '0;
            w_ed_out  = 1'b0;
            w_inx_out = 1'b0;
        end
    end

    // Datapath: latch operands, iterate, register rounded results on ROUND.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_my      <= '0;
            r_mode    <= '0;
            r_sz      <= 1'b0;
            r_x_zero  <= 1'b0;
            r_y_zero  <= 1'b0;
            r_done    <= 1'b0;
            r_mz      <= '0;
            r_exp_dec <= 1'b0;
            r_inexact <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem    <= {1'b0, Mx};
                        r_q      <= '0;
                        r_cnt    <= c_CNT_INIT;
                        r_my     <= My;
                        r_mode   <= R_mode;
                        r_sz     <= Sz;
                        r_x_zero <= (Mx == '0);
                        r_y_zero <= (My == '0);
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[c_QW-2:0], w_qbit};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    r_done    <= 1'b1;
                    r_mz      <= w_mz;
                    r_exp_dec <= w_ed_out;
                    r_inexact <= w_inx_out;
                    r_dbz     <= w_dbz_out;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign Mz          = r_mz;
    assign exp_dec     = r_exp_dec;
    assign inexact     = r_inexact;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
